ifetch_queue: RTL
=================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 64, PC/address width.
REQ-003 Parameter INSTR_W, default 32, instruction width.
REQ-004 Parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ireq_valid  out  1  instruction bus request valid.
REQ-008 ireq_addr  out  ADDR_W  request address.
REQ-009 iresp_addr_ok  in  1  bus accepted request this cycle.
REQ-010 iresp_data_ok  in  1  response data valid this cycle.
REQ-011 iresp_data  in  INSTR_W  response instruction.
REQ-012 redirect_valid  in  1  flush and restart fetch at redirect_pc.
REQ-013 redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored (forced 0).
REQ-014 out_valid  out  1  head entry valid.
REQ-015 out_pc  out  ADDR_W  PC of head entry.
REQ-016 out_instr  out  INSTR_W  instruction of head entry.
REQ-017 out_ready  in  1  decode consumes head when out_valid && out_ready.
REQ-018 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT; at most one request outstanding.
REQ-020 IDLE -> REQ when registered count < DEPTH and no redirect; else stay IDLE.
REQ-021 REQ: ireq_valid=1, ireq_addr=fetch_pc held stable until iresp_addr_ok; on addr_ok -> WAIT.
REQ-022 WAIT: on iresp_data_ok push {fetch_pc, iresp_data}, fetch_pc += 4 (mod 2^ADDR_W), -> IDLE.
REQ-023 Redirect in IDLE: flush queue, fetch_pc <= redirect_pc, stay IDLE; first new request next cycle.
REQ-024 Redirect in REQ without addr_ok: flush, load fetch_pc, -> DROP_REQ; ireq_valid and old ireq_addr held until addr_ok, then -> DROP_WAIT.
REQ-025 Redirect in REQ with addr_ok same cycle: flush, load fetch_pc, -> DROP_WAIT.
REQ-026 Redirect in WAIT (including same cycle as data_ok): flush, load fetch_pc; data_ok same cycle -> IDLE with data discarded, else -> DROP_WAIT.
REQ-027 DROP_WAIT: data_ok discarded, no push, fetch_pc unchanged, -> IDLE.
REQ-028 Redirect in DROP_REQ/DROP_WAIT: flush again, fetch_pc <= newest redirect_pc, state unchanged.
REQ-029 Queue is FIFO, first-word-fall-through; out_valid = (count != 0); out_pc/out_instr from head.
REQ-030 Push and pop same cycle: count unchanged; legal at count == DEPTH-1 and DEPTH.
REQ-031 Pop when empty ignored; push never occurs when full (guaranteed by REQ-020).
REQ-032 Redirect overrides same-cycle pop and push; count = 0 next cycle.
REQ-033 Read/write pointers wrap modulo DEPTH.
REQ-034 Latency: data_ok at cycle t -> out_valid=1 at t+1 (without bypass).

Reset
REQ-035 On reset assertion, immediately: state IDLE, fetch_pc=RESET_PC, count=0, pointers 0, ireq_valid=0, out_valid=0; outstanding transactions abandoned.
REQ-036 After reset release, first ireq_valid asserts at cycle 1 with ireq_addr=RESET_PC.

Configuration
REQ-037 Macro IFQ_BYPASS_EN: defined -> when count==0 and non-discarded data_ok, out_valid=1 same cycle with out_pc=fetch_pc, out_instr=iresp_data; entry not written if popped that cycle.
REQ-038 Without IFQ_BYPASS_EN: no combinational path from iresp_* to out_*; latency per REQ-034.

Verification
REQ-039 Reset, addr_ok/data_ok one cycle after request, out_ready=1 -> out_pc 0x80000000, 0x80000004, 0x80000008 in order.
REQ-040 DEPTH=4, out_ready=0 -> exactly 4 pushes, count=4, ireq_valid=0 thereafter; one pop -> one new request.
REQ-041 Redirect to 0x80001002 while in WAIT, then data_ok -> data dropped, next ireq_addr=0x80001000, count=0.
REQ-042 Redirect while ireq_valid and addr_ok stalled 3 cycles -> ireq_addr held old value, response dropped, then request 0x80001000.
REQ-043 Reset asserted mid-WAIT with count=3 -> outputs cleared immediately, restart at 0x80000000.
REQ-044 IFQ_BYPASS_EN defined, empty queue, data_ok=0x00000013 -> out_valid=1, out_instr=0x00000013 same cycle.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch FSM with one outstanding bus request feeding a
// first-word-fall-through instruction queue with redirect/flush.
//
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   ireq_valid/addr   - instruction bus request (addr held until addr_ok)
//   iresp_addr_ok     - bus accepted the request
//   iresp_data_ok     - response data valid, with iresp_data
//   redirect_valid/pc - flush queue, restart fetch at redirect_pc & ~3
//   out_valid/pc/instr- head of the queue toward decode
//   out_ready         - decode consumes head when out_valid && out_ready
//   count             - current queue occupancy
//
// Optional feature: define IFQ_BYPASS_EN to let a response into an empty
// queue appear on out_* in the same cycle it arrives.
module ifetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ireq_valid,
  output logic [ADDR_W-1:0]        ireq_addr,
  input  logic                     iresp_addr_ok,
  input  logic                     iresp_data_ok,
  input  logic [INSTR_W-1:0]       iresp_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP_REQ,
    DROP_WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [ADDR_W-1:0]  redir_pc;

  logic [ADDR_W-1:0]  pc_mem  [DEPTH];
  logic [INSTR_W-1:0] ins_mem [DEPTH];

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  logic has_room;
  logic empty;
  logic start_req;
  logic push;
  logic wr;
  logic pop;

  // Low two bits of the redirect target are dropped (word alignment).
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign has_room = (count_q < CW'(DEPTH));
  assign empty    = (count_q == '0);

  // ---------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect only flushes and reloads fetch_pc; a request already on
  // the bus must still complete its handshake, so it moves to a DROP
  // state whose response is thrown away.
  always_comb begin
    state_d   = state_q;
    start_req = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && has_room) begin
          state_d   = REQ;
          start_req = 1'b1;
        end
      end
      REQ: begin
        if (iresp_addr_ok) begin
          state_d = redirect_valid ? DROP_WAIT : WAIT;
        end else if (redirect_valid) begin
          state_d = DROP_REQ;
        end
      end
      WAIT: begin
        if (iresp_data_ok) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = DROP_WAIT;
        end
      end
      DROP_REQ: begin
        if (iresp_addr_ok) begin
          state_d = DROP_WAIT;
        end
      end
      DROP_WAIT: begin
        if (iresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ireq_valid = (state_q == REQ) || (state_q == DROP_REQ);
  assign ireq_addr  = req_addr_q;

  // ---------------------------------------------------------------
  // Fetch PC and the address held on the bus
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      if (start_req) begin
        req_addr_q <= fetch_pc_q;
      end
      if (redirect_valid) begin
        fetch_pc_q <= redir_pc;
      end else if (push) begin
        fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
      end
    end
  end

  // ---------------------------------------------------------------
  // Queue write/read selection
  // ---------------------------------------------------------------
`ifdef IFQ_BYPASS_EN
  logic byp;

  // Empty queue: the response goes straight to decode, and is only
  // stored if decode does not take it this cycle.
  assign byp       = push && empty;
  assign wr        = push && !(byp && out_ready);
  assign pop       = !empty && out_ready;
  assign out_valid = !empty || byp;
  assign out_pc    = byp ? fetch_pc_q : pc_mem[rptr_q];
  assign out_instr = byp ? iresp_data : ins_mem[rptr_q];
`else
  assign wr        = push;
  assign pop       = !empty && out_ready;
  assign out_valid = !empty;
  assign out_pc    = pc_mem[rptr_q];
  assign out_instr = ins_mem[rptr_q];
`endif

  assign count = count_q;

  // ---------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect_valid) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      unique case ({wr, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking masks stale entries.
  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[wptr_q]  <= fetch_pc_q;
      ins_mem[wptr_q] <= iresp_data;
    end
  end

endmodule
